// File: rtl/risc_mem_responder_if.sv
// Control/data bus between the VeriRisc controller and the memory responder.
// The err signal exists only when RISC_RESP_CHECK_EN is defined.
interface risc_mem_responder_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic [AWIDTH-1:0] addr;
    logic              rd;
    logic              data_e;
    logic              wr;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] rdata;
    logic              rvalid;
`ifdef RISC_RESP_CHECK_EN
    logic              err;

    modport master (
        output addr, rd, data_e, wr, wdata,
        input  rdata, rvalid, err
    );

    modport slave (
        input  addr, rd, data_e, wr, wdata,
        output rdata, rvalid, err
    );
`else
    modport master (
        output addr, rd, data_e, wr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, rd, data_e, wr, wdata,
        output rdata, rvalid
    );
`endif
endinterface

// File: rtl/risc_mem_responder.sv
// Memory-side responder for the VeriRisc bus: registered reads, data_e/wr paired writes.
// Define RISC_RESP_CHECK_EN to add the sticky protocol-error flag (bus.err).
module risc_mem_responder #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    risc_mem_responder_if.slave  bus
);

    // state  | meaning
    // IDLE   | no access in progress
    // READ   | read sampled last edge, rdata/rvalid hold its result
    // WSETUP | data_e seen without wr, a following wr is a paired commit
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WSETUP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              we;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // rd has priority over everything; a write needs data_e and wr with rd low.
    always_comb begin
        state_d  = IDLE;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        we       = 1'b0;
        if (bus.rd) begin
            state_d  = READ;
            rdata_d  = mem_q[bus.addr];
            rvalid_d = 1'b1;
        end else if (bus.data_e && !bus.wr) begin
            state_d = WSETUP;
        end else if (bus.data_e && bus.wr) begin
            we = 1'b1;
        end
    end

`ifdef RISC_RESP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (bus.rd && bus.wr)
            err_d = 1'b1;
        if (bus.wr && !bus.data_e)
            err_d = 1'b1;
        if (bus.wr && bus.data_e && state_q != WSETUP)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign bus.err = err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage is deliberately not reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (we)
            mem_q[bus.addr] <= bus.wdata;
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_risc_mem_responder.sv
// Directed self-checking bench for risc_mem_responder (both builds of RISC_RESP_CHECK_EN).
module tb_risc_mem_responder;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    risc_mem_responder_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

    risc_mem_responder #(.AWIDTH(5), .DWIDTH(8), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply strobes, then sample 1 time unit after the edge that consumes them.
    task automatic cyc(input logic rd, input logic de, input logic wr,
                       input logic [4:0] a, input logic [7:0] d);
        bus.rd     = rd;
        bus.data_e = de;
        bus.wr     = wr;
        bus.addr   = a;
        bus.wdata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    endtask

    task automatic write_word(input logic [4:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
        cyc(1'b0, 1'b1, 1'b1, a, d);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.rd     = 1'b0;
        bus.data_e = 1'b0;
        bus.wr     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdata", bus.rdata, 8'h00);
        check("reset_rvalid", {7'd0, bus.rvalid}, 8'h00);
`ifdef RISC_RESP_CHECK_EN
        check("reset_err", {7'd0, bus.err}, 8'h00);
`endif
        rst = 1'b0;
        idle();

        write_word(5'd5, 8'hA3);
        write_word(5'd2, 8'h21);
        write_word(5'd3, 8'h32);
        write_word(5'd4, 8'h43);
        write_word(5'd7, 8'h11);
        write_word(5'd1, 8'h5A);
        check("wcommit_rvalid", {7'd0, bus.rvalid}, 8'h00);
        idle();

        // single read, then idle holds rdata
        cyc(1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
        check("rd5_rdata", bus.rdata, 8'hA3);
        check("rd5_rvalid", {7'd0, bus.rvalid}, 8'h01);
        idle();
        check("idle_rdata_hold", bus.rdata, 8'hA3);
        check("idle_rvalid", {7'd0, bus.rvalid}, 8'h00);

        // paired write then immediate read-back
        cyc(1'b0, 1'b1, 1'b0, 5'd9, 8'h3C);
        check("wsetup_rdata_hold", bus.rdata, 8'hA3);
        check("wsetup_rvalid", {7'd0, bus.rvalid}, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 5'd9, 8'h3C);
        cyc(1'b1, 1'b0, 1'b0, 5'd9, 8'h00);
        check("rd9_rdata", bus.rdata, 8'h3C);
`ifdef RISC_RESP_CHECK_EN
        check("paired_err", {7'd0, bus.err}, 8'h00);
`endif

        // back-to-back reads
        cyc(1'b1, 1'b0, 1'b0, 5'd2, 8'h00);
        check("burst2_rdata", bus.rdata, 8'h21);
        check("burst2_rvalid", {7'd0, bus.rvalid}, 8'h01);
        cyc(1'b1, 1'b0, 1'b0, 5'd3, 8'h00);
        check("burst3_rdata", bus.rdata, 8'h32);
        check("burst3_rvalid", {7'd0, bus.rvalid}, 8'h01);
        cyc(1'b1, 1'b0, 1'b0, 5'd4, 8'h00);
        check("burst4_rdata", bus.rdata, 8'h43);
        check("burst4_rvalid", {7'd0, bus.rvalid}, 8'h01);
        idle();

        // rd wins over wr/data_e
        cyc(1'b1, 1'b1, 1'b1, 5'd7, 8'hFF);
        check("rdwr_rdata", bus.rdata, 8'h11);
        check("rdwr_rvalid", {7'd0, bus.rvalid}, 8'h01);
`ifdef RISC_RESP_CHECK_EN
        check("rdwr_err", {7'd0, bus.err}, 8'h01);
`endif
        cyc(1'b1, 1'b0, 1'b0, 5'd7, 8'h00);
        check("rd7_unchanged", bus.rdata, 8'h11);
        idle();

        // wr without data_e: no write
        cyc(1'b0, 1'b0, 1'b1, 5'd1, 8'h77);
        repeat (3) idle();
`ifdef RISC_RESP_CHECK_EN
        check("nowe_err_sticky", {7'd0, bus.err}, 8'h01);
`endif
        cyc(1'b1, 1'b0, 1'b0, 5'd1, 8'h00);
        check("rd1_unchanged", bus.rdata, 8'h5A);
        idle();

        // reset mid-setup discards the setup
        cyc(1'b0, 1'b1, 1'b0, 5'd12, 8'hC7);
        rst = 1'b1;
        #2;
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_rvalid", {7'd0, bus.rvalid}, 8'h00);
`ifdef RISC_RESP_CHECK_EN
        check("rst_err_clear", {7'd0, bus.err}, 8'h00);
`endif
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 5'd12, 8'hC7);
`ifdef RISC_RESP_CHECK_EN
        check("unpaired_err", {7'd0, bus.err}, 8'h01);
`endif
        cyc(1'b1, 1'b0, 1'b0, 5'd12, 8'h00);
        check("rd12_committed", bus.rdata, 8'hC7);
        check("rd12_rvalid", {7'd0, bus.rvalid}, 8'h01);
        cyc(1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
        check("mem_kept_rst", bus.rdata, 8'hA3);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
